// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write queue: command codes, word field
// positions, FSM state encoding and small word helpers.
package lcd_pkg;

    // Command codes accepted from the CPU
    localparam logic [3:0] LCD_CMD_INST = 4'd1;
    localparam logic [3:0] LCD_CMD_DATA = 4'd2;

    // Field positions inside the 32-bit CPU word and the 32-bit LCD word
    localparam int LCD_VALID_BIT = 31;
    localparam int LCD_RPT_MSB   = 30;
    localparam int LCD_RPT_LSB   = 20;
    localparam int LCD_CMD_MSB   = 19;
    localparam int LCD_CMD_LSB   = 16;
    localparam int LCD_DATA_MSB  = 15;
    localparam int LCD_DATA_LSB  = 0;

    // Derived widths
    localparam int LCD_RPT_W     = LCD_RPT_MSB - LCD_RPT_LSB + 1;   // 11
    localparam int LCD_ENTRY_W   = LCD_RPT_MSB + 1;                 // 31, stored per entry
    localparam int LCD_PAYLOAD_W = LCD_CMD_MSB + 1;                 // 20, cmd + data

    // Emission sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } lcd_state_e;

    // Only INST and DATA commands are meaningful to the LCD controller
    function automatic logic is_lcd_cmd(input logic [3:0] cmd);
        return (cmd == LCD_CMD_INST) || (cmd == LCD_CMD_DATA);
    endfunction

    // Build the word driven to the LCD controller from a {cmd, data} payload
    function automatic logic [31:0] lcd_pack(input logic [LCD_PAYLOAD_W-1:0] payload);
        logic [31:0] w;
        w = '0;
        w[LCD_VALID_BIT] = 1'b1;
        w[LCD_PAYLOAD_W-1:0] = payload;
        return w;
    endfunction

endpackage

// File: rtl/lcd_wr_queue_if.sv
// Bundle of the CPU-side write port, the LCD-side output word and the
// queue status/error flags.
//
// Handshake: there is no ready signal. wr_en is a single-cycle push strobe
// sampled on the rising clock edge; the word is accepted iff its cmd is
// INST/DATA and q_full is low in that same cycle, otherwise it is dropped
// and the matching sticky error flag is raised. lcd_word carries its own
// valid bit (bit 31) and is held for HOLD_CYCLES consecutive cycles per
// emission, separated by at least GAP_CYCLES cycles of all-zero output.
interface lcd_wr_queue_if
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16
) ();

    logic                     wr_en;
    logic [31:0]              wr_data;
    logic                     lcd_busy;
    logic                     clr_err;
    logic [31:0]              lcd_word;
    logic                     q_full;
    logic                     q_empty;
    logic [$clog2(DEPTH):0]   q_level;
    logic                     err_ovf;
    logic                     err_cmd;
    lcd_state_e               dbg_state;

    // CPU / LCD-controller side
    modport master (
        output wr_en, wr_data, lcd_busy, clr_err,
        input  lcd_word, q_full, q_empty, q_level, err_ovf, err_cmd, dbg_state
    );

    // Queue side
    modport slave (
        input  wr_en, wr_data, lcd_busy, clr_err,
        output lcd_word, q_full, q_empty, q_level, err_ovf, err_cmd, dbg_state
    );

endinterface

// File: rtl/lcd_sync_fifo.sv
// Single-clock FIFO with a registered storage array. Head entry is visible
// combinationally; full/empty are derived from the stored level.
module lcd_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [WIDTH-1:0]         o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_level == FULL_LEVEL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];

    // Requests are ignored when they would overrun or underrun the array
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // Pointer and level bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage write; contents need no reset since the level gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/lcd_wr_queue.sv
// LCD write queue: buffers CPU command/pixel words and replays each one to
// the LCD controller rpt+1 times, every emission held for HOLD_CYCLES and
// followed by GAP_CYCLES of idle output.
module lcd_wr_queue
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic          clk,
    input  logic          reset,
    lcd_wr_queue_if.slave bus
);

    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_CYCLES - 1);

    // Queue interface
    logic                     w_cmd_ok;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [LW-1:0]            w_fifo_level;
    logic [LCD_ENTRY_W-1:0]   w_head;
    logic                     w_unused_msb;

    // Sequencer state
    lcd_state_e               r_state;
    lcd_state_e               w_state_nxt;
    logic [HOLD_W-1:0]        r_hold_cnt;
    logic [HOLD_W-1:0]        w_hold_nxt;
    logic [GAP_W-1:0]         r_gap_cnt;
    logic [GAP_W-1:0]         w_gap_nxt;
    logic [LCD_RPT_W-1:0]     r_rep_cnt;
    logic [LCD_RPT_W-1:0]     w_rep_nxt;
    logic [LCD_PAYLOAD_W-1:0] r_out;
    logic [LCD_PAYLOAD_W-1:0] w_out_nxt;
    logic [31:0]              r_lcd_word;
    logic [31:0]              w_word_nxt;

    // Sticky error flags
    logic                     r_err_ovf;
    logic                     r_err_cmd;

    // Bit 31 of the CPU word carries no information
    assign w_unused_msb = bus.wr_data[LCD_VALID_BIT];

    assign w_cmd_ok = is_lcd_cmd(bus.wr_data[LCD_CMD_MSB:LCD_CMD_LSB]);
    assign w_push   = bus.wr_en && w_cmd_ok && !w_fifo_full;

    lcd_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LCD_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.wr_data[LCD_ENTRY_W-1:0]),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level),
        .o_head  (w_head)
    );

    // Next-state logic: start an entry from IDLE, hold it, gap, then repeat or pop
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_rep_nxt   = r_rep_cnt;
        w_out_nxt   = r_out;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                // lcd_busy only gates the start of a new entry
                if (!w_fifo_empty && !bus.lcd_busy) begin
                    w_state_nxt = HOLD;
                    w_out_nxt   = {w_head[LCD_CMD_MSB:LCD_CMD_LSB],
                                   w_head[LCD_DATA_MSB:LCD_DATA_LSB]};
                    w_rep_nxt   = w_head[LCD_RPT_MSB:LCD_RPT_LSB];
                    w_hold_nxt  = HOLD_INIT;
                end
            end
            HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = GAP;
                    w_gap_nxt   = GAP_INIT;
                end else begin
                    w_hold_nxt  = r_hold_cnt - HOLD_W'(1);
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    if (r_rep_cnt != '0) begin
                        w_rep_nxt   = r_rep_cnt - LCD_RPT_W'(1);
                        w_hold_nxt  = HOLD_INIT;
                        w_state_nxt = HOLD;
                    end else begin
                        // Entry leaves the queue only after its last gap
                        w_pop       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Output word is computed from the next state so the register tracks HOLD exactly
        w_word_nxt = (w_state_nxt == HOLD) ? lcd_pack(w_out_nxt) : 32'd0;
    end

    // Sequencer registers and the registered LCD output word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_rep_cnt  <= '0;
            r_out      <= '0;
            r_lcd_word <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_out      <= w_out_nxt;
            r_lcd_word <= w_word_nxt;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_ovf <= 1'b0;
            r_err_cmd <= 1'b0;
        end else begin
            if (bus.wr_en && w_cmd_ok && w_fifo_full) begin
                r_err_ovf <= 1'b1;
            end else if (bus.clr_err) begin
                r_err_ovf <= 1'b0;
            end
            if (bus.wr_en && !w_cmd_ok) begin
                r_err_cmd <= 1'b1;
            end else if (bus.clr_err) begin
                r_err_cmd <= 1'b0;
            end
        end
    end

    assign bus.lcd_word  = r_lcd_word;
    assign bus.q_full    = w_fifo_full;
    assign bus.q_empty   = w_fifo_empty;
    assign bus.q_level   = w_fifo_level;
    assign bus.err_ovf   = r_err_ovf;
    assign bus.err_cmd   = r_err_cmd;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_lcd_wr_queue.sv
// Directed testbench for lcd_wr_queue: single emission, repeated fill,
// overflow with lcd_busy, bad commands, mid-emission reset and push/pop overlap.
module tb_lcd_wr_queue;
  import lcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lcd_wr_queue_if #(.DEPTH(16)) bus ();

  lcd_wr_queue #(
    .DEPTH       (16),
    .HOLD_CYCLES (2),
    .GAP_CYCLES  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
    bus.wr_data = 32'd0;
  endtask

  // Watch the output for a bounded number of cycles; every 0->valid transition
  // must match the next expected word, and none may appear once exp_q is empty
  task automatic drain(input string tag, input int max_cycles);
    logic [31:0] prev;
    prev = 32'd0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      if (bus.lcd_word != 32'd0 && prev == 32'd0) begin
        if (exp_q.size() != 0) begin
          check({tag, "_word"}, bus.lcd_word, exp_q.pop_front());
        end else begin
          check({tag, "_extra"}, bus.lcd_word, 32'd0);
        end
      end
      prev = bus.lcd_word;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_empty"}, 32'(bus.q_empty), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_data  = 32'd0;
    bus.lcd_busy = 1'b0;
    bus.clr_err  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_word",  bus.lcd_word, 32'd0);
    check("rst_level", 32'(bus.q_level), 32'd0);
    check("rst_full",  32'(bus.q_full), 32'd0);
    check("rst_empty", 32'(bus.q_empty), 32'd1);
    check("rst_ovf",   32'(bus.err_ovf), 32'd0);
    check("rst_cmd",   32'(bus.err_cmd), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Single INST word: stored, then 2 valid cycles, 1 zero cycle, popped
    push(32'h0001_2C00);
    check("t1_stored_level", 32'(bus.q_level), 32'd1);
    check("t1_stored_word",  bus.lcd_word, 32'd0);
    check("t1_stored_empty", 32'(bus.q_empty), 32'd0);
    tick();
    check("t1_hold0", bus.lcd_word, 32'h8001_2C00);
    tick();
    check("t1_hold1", bus.lcd_word, 32'h8001_2C00);
    tick();
    check("t1_gap",       bus.lcd_word, 32'd0);
    check("t1_gap_level", 32'(bus.q_level), 32'd1);
    tick();
    check("t1_done_word",  bus.lcd_word, 32'd0);
    check("t1_done_empty", 32'(bus.q_empty), 32'd1);
    check("t1_done_level", 32'(bus.q_level), 32'd0);

    // rpt=3 DATA red: 4 x (2 hold + 1 gap) = 12 cycles, level 1 throughout
    push(32'h0032_F800);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("t2_word_%0d", i), bus.lcd_word,
            ((i % 3) < 2) ? 32'h8002_F800 : 32'd0);
      check($sformatf("t2_level_%0d", i), 32'(bus.q_level), 32'd1);
    end
    tick();
    check("t2_done_level", 32'(bus.q_level), 32'd0);
    check("t2_done_word",  bus.lcd_word, 32'd0);

    // 17 pushes with lcd_busy high: full after 16, 17th dropped as overflow
    bus.lcd_busy = 1'b1;
    for (int k = 0; k < 17; k++) begin
      w = {1'b0, 11'd0, (k % 2 == 1) ? LCD_CMD_DATA : LCD_CMD_INST, 16'hA500 + 16'(k)};
      if (k < 16) exp_q.push_back({1'b1, 11'd0, w[19:0]});
      if (k == 16) begin
        check("t3_full_at16", 32'(bus.q_full), 32'd1);
        check("t3_ovf_before", 32'(bus.err_ovf), 32'd0);
      end
      push(w);
    end
    check("t3_ovf",   32'(bus.err_ovf), 32'd1);
    check("t3_level", 32'(bus.q_level), 32'd16);
    check("t3_busy_word", bus.lcd_word, 32'd0);
    tick();
    check("t3_busy_word2", bus.lcd_word, 32'd0);
    bus.lcd_busy = 1'b0;
    drain("t3", 80);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("t3_ovf_cleared", 32'(bus.err_ovf), 32'd0);

    // Bad command dropped; clear races with another bad push and loses
    push(32'h0003_1234);
    check("t4_cmd_err",   32'(bus.err_cmd), 32'd1);
    check("t4_cmd_level", 32'(bus.q_level), 32'd0);
    bus.clr_err = 1'b1;
    tick();
    check("t4_cmd_clear", 32'(bus.err_cmd), 32'd0);
    push(32'h0000_0001);
    check("t4_cmd_race", 32'(bus.err_cmd), 32'd1);
    bus.clr_err = 1'b0;
    tick();
    check("t4_cmd_hold", 32'(bus.err_cmd), 32'd1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("t4_cmd_clear2", 32'(bus.err_cmd), 32'd0);

    // Reset during the 2nd repeat of an rpt=5 entry, with a second entry queued
    push(32'h0051_ABCD);
    push(32'h0002_0001);
    check("t5_rep1", bus.lcd_word, 32'h8001_ABCD);
    tick();
    tick();
    check("t5_gap1", bus.lcd_word, 32'd0);
    tick();
    check("t5_rep2",   bus.lcd_word, 32'h8001_ABCD);
    check("t5_level2", 32'(bus.q_level), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_word",  bus.lcd_word, 32'd0);
    check("t5_rst_level", 32'(bus.q_level), 32'd0);
    check("t5_rst_state", 32'(bus.dbg_state), 32'(IDLE));
    tick();
    tick();
    tick();
    check("t5_after_word", bus.lcd_word, 32'd0);

    // Push and pop in the same cycle at level 8
    bus.lcd_busy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = {1'b0, 11'd0, LCD_CMD_DATA, 16'h0100 + 16'(k)};
      exp_q.push_back({1'b1, 11'd0, w[19:0]});
      push(w);
    end
    check("t6_level8", 32'(bus.q_level), 32'd8);
    bus.lcd_busy = 1'b0;
    tick();
    check("t6_first", bus.lcd_word, exp_q.pop_front());
    tick();
    tick();
    check("t6_gap", bus.lcd_word, 32'd0);
    w = {1'b0, 11'd0, LCD_CMD_INST, 16'h0BEE};
    exp_q.push_back({1'b1, 11'd0, w[19:0]});
    push(w);
    check("t6_level_same", 32'(bus.q_level), 32'd8);
    drain("t6", 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
